// File: rtl/add_pkg.sv
// Shared types and helpers for the streaming frame accumulator.
//   state_e  : accumulator FSM states
//   eff_len  : maps a requested frame length onto 1..M
//   AllOnes / Zero : wide constants, sliced to the data width at the use site
package add_pkg;

  // Widest data width the wide constants cover; N must not exceed this.
  localparam int unsigned MaxW = 256;

  localparam logic [MaxW-1:0] AllOnes = {MaxW{1'b1}};
  localparam logic [MaxW-1:0] Zero    = {MaxW{1'b0}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  // A length of 0 or anything above m means a full-size frame of m words.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned m);
    return ((len == 0) || (len > m)) ? m : len;
  endfunction

endpackage

// File: rtl/add_sat_n.sv
// Combinational N-bit adder step with wrap or saturate behaviour.
//   a, b       : operands
//   sticky_in  : overflow already seen earlier in the frame
//   sum        : next accumulator value
//   sticky_out : overflow seen up to and including this step
// SAT=0 wraps and ORs the carry into the sticky flag.
// SAT=1 pins the result at all-ones once any overflow has occurred.
module add_sat_n #(
  parameter int unsigned N   = 32,
  parameter int unsigned SAT = 0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sticky_in,
  output logic [N-1:0] sum,
  output logic         sticky_out
);
  import add_pkg::*;

  logic [N:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    if (SAT != 0) begin
      if (full[N] || sticky_in) begin
        sum        = AllOnes[N-1:0];
        sticky_out = 1'b1;
      end else begin
        sum        = full[N-1:0];
        sticky_out = 1'b0;
      end
    end else begin
      sum        = full[N-1:0];
      sticky_out = sticky_in | full[N];
    end
  end

endmodule

// File: rtl/add_stream_n_m.sv
// Streaming frame accumulator: sums 1..M serially delivered N-bit words and
// presents one N-bit result with an overflow flag per frame.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-low reset
//   data_i / valid_i / ready_o : word input handshake
//   len_i   : frame length, sampled with the first word (0 or >M means M)
//   sum_o / c_o / valid_o / ready_i : result output handshake
//   fl_end  : one-cycle pulse after the result handshake
module add_stream_n_m #(
  parameter int unsigned N   = 32,
  parameter int unsigned M   = 4,
  parameter int unsigned SAT = 0,
  parameter int unsigned LW  = $clog2(M + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  data_i,
  input  logic          valid_i,
  input  logic [LW-1:0] len_i,
  output logic          ready_o,
  output logic [N-1:0]  sum_o,
  output logic          c_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          fl_end
);
  import add_pkg::*;

  state_e        state_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] len_q;
  logic [N-1:0]  acc_q;
  logic          c_q;
  logic          ready_q;
  logic          valid_q;
  logic          fl_end_q;

  logic [LW-1:0] len_eff;
  logic [LW-1:0] cnt_inc;
  logic [N-1:0]  add_sum;
  logic          add_sticky;
  logic          word_xfer;

  assign len_eff   = LW'(eff_len(32'(len_i), M));
  assign cnt_inc   = cnt_q + LW'(1);
  assign word_xfer = valid_i & ready_q;

  add_sat_n #(
    .N   (N),
    .SAT (SAT)
  ) u_add (
    .a          (acc_q),
    .b          (data_i),
    .sticky_in  (c_q),
    .sum        (add_sum),
    .sticky_out (add_sticky)
  );

  // ready/valid/fl_end are registered alongside the state so that ready_o
  // stays low for the reset cycle and rises one cycle after reset releases.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= LW'(M);
      acc_q    <= Zero[N-1:0];
      c_q      <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      fl_end_q <= 1'b0;
    end else begin
      fl_end_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (word_xfer) begin
            acc_q <= data_i;
            cnt_q <= LW'(1);
            c_q   <= 1'b0;
            len_q <= len_eff;
            if (len_eff == LW'(1)) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StAcc: begin
          if (word_xfer) begin
            acc_q <= add_sum;
            c_q   <= add_sticky;
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (ready_i) begin
            state_q  <= StIdle;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            fl_end_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign sum_o   = acc_q;
  assign c_o     = c_q;
  assign fl_end  = fl_end_q;

endmodule

// File: tb/tb_add_stream_n_m.sv
// Directed bench: one wrap-mode and one saturate-mode instance share stimulus.
module tb_add_stream_n_m;

  localparam int unsigned N  = 8;
  localparam int unsigned M  = 4;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [N-1:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          ready_i = 1'b1;

  logic          ready_w, valid_w, c_w, fl_end_w;
  logic [N-1:0]  sum_w;
  logic          ready_s, valid_s, c_s, fl_end_s;
  logic [N-1:0]  sum_s;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  add_stream_n_m #(.N(N), .M(M), .SAT(0)) u_dut_wrap (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .len_i   (len_i),
    .ready_o (ready_w),
    .sum_o   (sum_w),
    .c_o     (c_w),
    .valid_o (valid_w),
    .ready_i (ready_i),
    .fl_end  (fl_end_w)
  );

  add_stream_n_m #(.N(N), .M(M), .SAT(1)) u_dut_sat (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .len_i   (len_i),
    .ready_o (ready_s),
    .sum_o   (sum_s),
    .c_o     (c_s),
    .valid_o (valid_s),
    .ready_i (ready_i),
    .fl_end  (fl_end_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one word; returns #1 after the edge that transfers it.
  task automatic send(input logic [N-1:0] d, input logic [LW-1:0] l);
    int n = 0;
    @(negedge clk);
    data_i  = d;
    len_i   = l;
    valid_i = 1'b1;
    while (!ready_w && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // With ready_i high the result is taken on the next edge; fl_end follows.
  task automatic accept(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_fl_end"}, 32'(fl_end_w), 32'd1);
    check({tag, "_valid_low"}, 32'(valid_w), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_sum", 32'(sum_w), 32'd0);
    check("rst_c", 32'(c_w), 32'd0);
    check("rst_valid", 32'(valid_w), 32'd0);
    check("rst_fl_end", 32'(fl_end_w), 32'd0);
    check("rst_ready", 32'(ready_w), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 check("post_rst_ready", 32'(ready_w), 32'd1);

    // Frame 10,20,30,40
    ready_i = 1'b1;
    send(8'd10, 3'd4);
    send(8'd20, 3'd4);
    send(8'd30, 3'd4);
    check("f1_not_yet", 32'(valid_w), 32'd0);
    send(8'd40, 3'd4);
    check("f1_valid", 32'(valid_w), 32'd1);
    check("f1_sum", 32'(sum_w), 32'd100);
    check("f1_c", 32'(c_w), 32'd0);
    check("f1_ready_low", 32'(ready_w), 32'd0);
    accept("f1");
    check("f1_ready_back", 32'(ready_w), 32'd1);
    @(posedge clk);
    #1 check("f1_fl_end_drop", 32'(fl_end_w), 32'd0);

    // Overflow: wrap vs saturate
    send(8'd200, 3'd3);
    send(8'd100, 3'd3);
    send(8'd10, 3'd3);
    check("ovf_wrap_sum", 32'(sum_w), 32'd54);
    check("ovf_wrap_c", 32'(c_w), 32'd1);
    check("ovf_sat_valid", 32'(valid_s), 32'd1);
    check("ovf_sat_sum", 32'(sum_s), 32'd255);
    check("ovf_sat_c", 32'(c_s), 32'd1);
    accept("ovf");

    send(8'd255, 3'd3);
    send(8'd0, 3'd3);
    send(8'd0, 3'd3);
    check("max_sat_sum", 32'(sum_s), 32'd255);
    check("max_sat_c", 32'(c_s), 32'd0);
    check("max_wrap_c", 32'(c_w), 32'd0);
    accept("max");

    // Single-word frame
    send(8'd7, 3'd1);
    check("len1_valid", 32'(valid_w), 32'd1);
    check("len1_sum", 32'(sum_w), 32'd7);
    accept("len1");

    // len=0 means M words
    send(8'd1, 3'd0);
    send(8'd1, 3'd0);
    send(8'd1, 3'd0);
    check("len0_not_yet", 32'(valid_w), 32'd0);
    send(8'd1, 3'd0);
    check("len0_valid", 32'(valid_w), 32'd1);
    check("len0_sum", 32'(sum_w), 32'd4);
    accept("len0");

    // Backpressure in DONE
    ready_i = 1'b0;
    send(8'd5, 3'd2);
    send(8'd6, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_i  = 8'd99;
      valid_i = 1'b1;
      check("bp_ready", 32'(ready_w), 32'd0);
      check("bp_valid", 32'(valid_w), 32'd1);
      check("bp_sum", 32'(sum_w), 32'd11);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("bp_sum_final", 32'(sum_w), 32'd11);
    @(posedge clk);
    #1;
    check("bp_fl_end", 32'(fl_end_w), 32'd1);
    check("bp_valid_low", 32'(valid_w), 32'd0);

    // Bubbles inside a frame
    send(8'd1, 3'd3);
    repeat (3) @(negedge clk);
    check("bub_hold", 32'(valid_w), 32'd0);
    send(8'd2, 3'd3);
    repeat (2) @(negedge clk);
    send(8'd3, 3'd3);
    check("bub_sum", 32'(sum_w), 32'd6);
    accept("bub");

    // Reset mid-frame
    send(8'd1, 3'd4);
    send(8'd2, 3'd4);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(valid_w), 32'd0);
    check("mid_rst_sum", 32'(sum_w), 32'd0);
    check("mid_rst_c", 32'(c_w), 32'd0);
    check("mid_rst_fl_end", 32'(fl_end_w), 32'd0);
    check("mid_rst_ready", 32'(ready_w), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    send(8'd1, 3'd4);
    send(8'd2, 3'd4);
    send(8'd3, 3'd4);
    check("after_rst_not_yet", 32'(valid_w), 32'd0);
    send(8'd4, 3'd4);
    check("after_rst_valid", 32'(valid_w), 32'd1);
    check("after_rst_sum", 32'(sum_w), 32'd10);
    accept("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/add_stream_n_m.md
Name: add_stream_n_m

Overview:
- Streaming frame accumulator: sums a frame of 1..M serially delivered N-bit words and presents one N-bit result plus overflow flag.
- Next generation of the fixed-depth parallel summer:
  - valid/ready handshake on both sides
  - runtime frame length
  - selectable wrap or saturate arithmetic
  - end-of-frame pulse
- Sits between a word producer (ADC/DMA/bus slave) and a result consumer; one result per frame.

Parameters:
- N, 32, data and sum width in bits (N >= 2).
- M, 4, maximum words per frame (M >= 1).
- SAT, 0, 0 = wrap arithmetic with sticky carry; 1 = saturate at all-ones.
- LW, $clog2(M+1), width of len_i (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- data_i  input  N  input word.
- valid_i  input  1  data_i valid.
- len_i  input  LW  frame length; sampled with first word of frame; 0 or >M treated as M.
- ready_o  output  1  block can accept a word.
- sum_o  output  N  frame sum.
- c_o  output  1  overflow occurred in this frame (sticky within frame).
- valid_o  output  1  sum_o/c_o valid.
- ready_i  input  1  consumer accepts result.
- fl_end  output  1  one-cycle pulse after result handshake.

Behaviour:
- Reset: rst_i=0 at a clock edge forces:
  - state IDLE, cnt=0, len_q=M
  - sum_o=0, c_o=0, valid_o=0, fl_end=0
  - ready_o=0 during the reset cycle, 1 in the first cycle after rst_i returns to 1.
- Reset mid-frame or while in DONE discards the frame; no result and no fl_end are produced.
- Word transfer occurs when valid_i & ready_o; result transfer occurs when valid_o & ready_i.
- ready_o is registered-state derived: 1 in IDLE and ACC, 0 in DONE. valid_o=1 only in DONE.
- IDLE:
  - On a word transfer: acc<=data_i, cnt<=1, c<=0, len_q<=effective len_i.
  - If effective len=1, go to DONE; else go to ACC.
- ACC:
  - On a word transfer: {carry,acc_next} = acc + data_i computed in N+1 bits; cnt<=cnt+1.
  - When cnt+1 == len_q, go to DONE.
  - With valid_i=0, hold all state (bubbles allowed; no timeout).
- Arithmetic, SAT=0: acc<=acc_next[N-1:0]; c<=c|carry.
- Arithmetic, SAT=1:
  - If carry or c already set: acc<=all-ones and c<=1.
  - Saturation is sticky; later words cannot reduce acc.
- DONE:
  - sum_o=acc and c_o=c, held stable until ready_i.
  - On ready_i, go to IDLE and assert fl_end=1 for exactly the next cycle.
- Latency:
  - valid_o rises the cycle after the last word transfer.
  - If ready_i is held high, the result is accepted in that same cycle and ready_o returns to 1 the following cycle.
  - Back-to-back frames therefore cost len+1 cycles each.
- sum_o and c_o outside DONE: hold their last value (not guaranteed meaningful); checkers sample only when valid_o=1.
- Simultaneous events:
  - No word accepted in DONE.
  - fl_end may coincide with first-word acceptance of the next frame.
- cnt width LW; cnt never exceeds len_q.

Decomposition:
- Package add_pkg:
  - state enum {IDLE, ACC, DONE} (2-bit)
  - function eff_len(len, M)
  - localparams for all-ones and zero constants of width N.
- One sub-module, add_sat_n (parameters N, SAT):
  - combinational inputs a, b, sticky_in
  - outputs sum, sticky_out; implements the wrap/saturate rule.
- The top holds the FSM, counter and registers.

Test Plan:
- N=8, M=4, SAT=0, len=4, words 10,20,30,40, ready_i=1:
  - valid_o high the cycle after 4th transfer, sum_o=100, c_o=0
  - fl_end pulses next cycle.
- N=8, SAT=0, len=3, words 200,100,10 -> sum_o=54, c_o=1.
- Same words with SAT=1 -> sum_o=255, c_o=1; also 255,0,0 -> sum_o=255, c_o=0.
- len=1, word 7:
  - valid_o next cycle, sum_o=7.
  - len=0 with words 1,1,1,1 -> result only after 4th word, sum_o=4.
- Backpressure and bubbles: ready_i=0 for 5 cycles in DONE -> sum_o stable, ready_o=0, extra valid_i words not accepted; valid_i gaps inside ACC do not change the sum.
- rst_i=0 for one cycle after 2 of 4 words -> no valid_o, all outputs 0; next frame 1,2,3,4 gives sum_o=10.
